alu_op_dispatcher: RTL and testbench
====================================

Name: alu_op_dispatcher

Overview:
- Initiator side of the start/working/ack handshake used by the add, sub, mul and div execution units.
- Accepts one operation request at a time from the upstream sequencer.
- Drives shared operands and a one-hot start to the selected unit, waits until that unit is the sole working unit, lets the result settle, then captures it.
- Returns the result through a valid/ready response port, with timeout protection.

Parameters:
- WIDTH, 64, operand and result width.
- SETTLE_CYC, 2, cycles to hold start after exclusive grant before sampling the result (1..15).
- TIMEOUT_CYC, 64, maximum cycles to wait for exclusive grant before aborting (2..1023).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  dispatcher can accept a request.
- req_op  input  2  operation select: 0=add, 1=sub, 2=mul, 3=div.
- req_a  input  WIDTH  operand a.
- req_b  input  WIDTH  operand b.
- unit_a  output  WIDTH  registered operand a bus to all units.
- unit_b  output  WIDTH  registered operand b bus to all units.
- unit_start  output  4  one-hot start; bit order add, sub, mul, div.
- unit_working  input  4  working flags from the units, same bit order.
- res_add  input  WIDTH  add unit result.
- res_sub  input  WIDTH  sub unit result.
- res_mul  input  WIDTH  mul unit result.
- res_div  input  WIDTH  div unit result.
- resp_valid  output  1  response present.
- resp_ready  input  1  downstream accepts response.
- resp_data  output  WIDTH  captured result; 0 on error.
- resp_err  output  1  1 = timeout or rejected operation.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE; req_ready=1; unit_start=0; unit_a=0; unit_b=0; resp_valid=0; resp_data=0; resp_err=0; busy=0; counters 0.
- All outputs are registered.
- States:
  - IDLE: req_ready=1. When req_valid and req_ready are both high, latch op, a and b into unit_a/unit_b, drop req_ready, and go to WAIT_FREE.
  - WAIT_FREE: unit_start=0. Stay until unit_working==0, then go to GRANT. Timeout counter runs from WAIT_FREE entry.
  - GRANT: unit_start = one-hot(op). Go to SETTLE when unit_working equals exactly one-hot(op). A peer bit still set is not exclusive; keep waiting.
  - SETTLE: start held; count SETTLE_CYC cycles. If unit_working deviates from one-hot(op), return to GRANT; the settle count restarts, the timeout count does not. On count done, capture the selected res_* into resp_data with resp_err=0, drop start, go to RESP.
  - RESP: resp_valid=1, with data and err stable until resp_ready. On the handshake, clear resp_valid and go to IDLE, where req_ready=1 the next cycle.
- Timeout: if WAIT_FREE plus GRANT together reach TIMEOUT_CYC cycles, drop start and go to RESP with resp_data=0, resp_err=1.
- Minimum latency, req accept to resp_valid: 2+SETTLE_CYC cycles (units free and responding immediately).
- No request is accepted while busy. req_ready is never high in the same cycle as resp_valid.
- A unit_working bit asserted outside this dispatcher's start is tolerated and only delays the grant.
- rst mid-operation: immediate return to reset values; start is deasserted asynchronously; the in-flight operation is lost with no response.
- resp_ready high outside RESP is ignored.

Optional Feature:
- Macro ALU_DISPATCH_DIV0_CHECK_EN.
- Defined: in IDLE, an accepted div with req_b==0 skips the unit entirely and goes directly to RESP with resp_data=0, resp_err=1. Latency is 1 cycle and unit_start never asserts.
- Undefined: div by zero is dispatched normally and the div unit's result is returned with resp_err=0.

Test Plan:
- Reset with rst pulsed mid-GRANT -> unit_start drops asynchronously to 0; after release, req_ready=1 and resp_valid=0.
- mul, a=3, b=7; unit_working=4'b0100 one cycle after start; res_mul=21 -> resp_valid at cycle 4 (SETTLE_CYC=2) with resp_data=21 and resp_err=0; unit_start=4'b0100 only during GRANT/SETTLE.
- add requested while unit_working=4'b1000 for 10 cycles -> start stays 0 throughout, grant follows after the unit frees, result returned with resp_err=0.
- sub with unit_working stuck at 4'b0011, TIMEOUT_CYC=64 -> resp_valid with resp_data=0 and resp_err=1 after 64 cycles; start dropped.
- resp_ready held low for 5 cycles in RESP -> resp_data stable and req_ready=0 throughout; after the handshake, a back-to-back request is accepted the next cycle.
- With ALU_DISPATCH_DIV0_CHECK_EN defined: div with b=0 -> resp_err=1 one cycle after accept and unit_start never asserts. Without the macro: the unit is started normally.

Source files
------------

// File: rtl/alu_op_dispatcher.sv
// -----------------------------------------------------------------------------
// alu_op_dispatcher
//
// Initiator side of the start/working/ack handshake shared by the add, sub,
// mul and div execution units. One request is taken at a time from the
// upstream sequencer. Its operands go onto the shared operand buses and the
// selected unit gets a one-hot start. The dispatcher waits until that unit is
// the only one reporting working, holds start for a settle window, and then
// captures the unit's result. The response goes out through a valid/ready
// port. A request that cannot get exclusive use of its unit within
// TIMEOUT_CYC cycles is aborted with an error response.
//
// Optional feature (compile-time macro ALU_DISPATCH_DIV0_CHECK_EN):
//   defined   - a div request with req_b == 0 never reaches the div unit. It
//               is answered one cycle after accept with resp_data = 0 and
//               resp_err = 1.
//   undefined - div by zero is dispatched like any other operation.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_op                   0=add 1=sub 2=mul 3=div
//   req_a, req_b             operands
//   unit_a, unit_b           registered operand buses to all units
//   unit_start[3:0]          one-hot start, bit order add, sub, mul, div
//   unit_working[3:0]        working flags from the units, same bit order
//   res_add/sub/mul/div      unit results
//   resp_valid/resp_ready    response handshake
//   resp_data, resp_err      captured result (0 on error), error flag
//   busy                     high whenever the dispatcher is not idle
//
// Parameters:
//   WIDTH        operand/result width
//   SETTLE_CYC   cycles start is held after exclusive grant (1..15)
//   TIMEOUT_CYC  cycle budget for WAIT_FREE + GRANT (2..1023)
// -----------------------------------------------------------------------------
module alu_op_dispatcher #(
    parameter int WIDTH       = 64,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    output logic [3:0]       unit_start,
    input  logic [3:0]       unit_working,
    input  logic [WIDTH-1:0] res_add,
    input  logic [WIDTH-1:0] res_sub,
    input  logic [WIDTH-1:0] res_mul,
    input  logic [WIDTH-1:0] res_div,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FREE = 3'd1,
        GRANT     = 3'd2,
        SETTLE    = 3'd3,
        RESP      = 3'd4
    } state_t;

    localparam int TCW = 10;   // holds TIMEOUT_CYC-1 up to 1022
    localparam int SCW = 4;    // holds SETTLE_CYC-1 up to 14

    // Terminal counts: the counter value seen during the last allowed cycle.
    localparam logic [TCW-1:0] TMO_LAST    = TCW'(TIMEOUT_CYC - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             reject_q, reject_d;
    logic [TCW-1:0]   tcnt_q, tcnt_d;
    logic [SCW-1:0]   scnt_q, scnt_d;
    logic             req_ready_q, req_ready_d;
    logic [WIDTH-1:0] unit_a_q, unit_a_d;
    logic [WIDTH-1:0] unit_b_q, unit_b_d;
    logic [3:0]       unit_start_q, unit_start_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;
    logic             busy_q, busy_d;

    logic [3:0]       op_onehot;
    logic [WIDTH-1:0] sel_res;
    logic             div0_hit;
    logic             exclusive;

    // One-hot decode of the latched operation.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign op_onehot[gi] = (op_q == 2'(gi));
        end
    endgenerate

    // Exclusive grant means the selected unit is working and no peer is.
    assign exclusive = (unit_working == op_onehot);

`ifdef ALU_DISPATCH_DIV0_CHECK_EN
    assign div0_hit = (req_op == 2'd3) && (req_b == '0);
`else
    assign div0_hit = 1'b0;
`endif

    always_comb begin
        sel_res = res_add;
        case (op_q)
            2'd0:    sel_res = res_add;
            2'd1:    sel_res = res_sub;
            2'd2:    sel_res = res_mul;
            default: sel_res = res_div;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        reject_d     = reject_q;
        tcnt_d       = tcnt_q;
        scnt_d       = scnt_q;
        req_ready_d  = req_ready_q;
        unit_a_d     = unit_a_q;
        unit_b_d     = unit_b_q;
        unit_start_d = unit_start_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                unit_start_d = '0;
                if (req_valid && req_ready_q) begin
                    op_d        = req_op;
                    unit_a_d    = req_a;
                    unit_b_d    = req_b;
                    reject_d    = div0_hit;
                    tcnt_d      = '0;
                    scnt_d      = '0;
                    req_ready_d = 1'b0;
                    state_d     = WAIT_FREE;
                end
            end

            WAIT_FREE: begin
                // A rejected request passes through here for one cycle so the
                // error answer appears one cycle after accept, like a normal
                // registered response, and never touches the units.
                if (reject_q || (tcnt_q == TMO_LAST)) begin
                    unit_start_d = '0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (unit_working == 4'b0000) begin
                        unit_start_d = op_onehot;
                        state_d      = GRANT;
                    end
                end
            end

            GRANT: begin
                if (tcnt_q == TMO_LAST) begin
                    unit_start_d = '0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (exclusive) begin
                        scnt_d  = '0;
                        state_d = SETTLE;
                    end
                end
            end

            SETTLE: begin
                // Losing exclusivity sends us back to GRANT with start still
                // held; the timeout budget keeps its accumulated value.
                if (!exclusive) begin
                    scnt_d  = '0;
                    state_d = GRANT;
                end else if (scnt_q == SETTLE_LAST) begin
                    unit_start_d = '0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = sel_res;
                    resp_err_d   = 1'b0;
                    state_d      = RESP;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end

            RESP: begin
                unit_start_d = '0;
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end

            default: begin
                unit_start_d = '0;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= 2'd0;
            reject_q     <= 1'b0;
            tcnt_q       <= '0;
            scnt_q       <= '0;
            req_ready_q  <= 1'b1;
            unit_a_q     <= '0;
            unit_b_q     <= '0;
            unit_start_q <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            reject_q     <= reject_d;
            tcnt_q       <= tcnt_d;
            scnt_q       <= scnt_d;
            req_ready_q  <= req_ready_d;
            unit_a_q     <= unit_a_d;
            unit_b_q     <= unit_b_d;
            unit_start_q <= unit_start_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign unit_a     = unit_a_q;
    assign unit_b     = unit_b_q;
    assign unit_start = unit_start_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// -----------------------------------------------------------------------------
// Testbench for alu_op_dispatcher (WIDTH=64, SETTLE_CYC=2, TIMEOUT_CYC=64).
// The execution units are emulated: results are plain arithmetic on the
// operand buses, and a unit reports working in the same cycle its start is
// visible (auto_en), optionally OR-ed with an injected mask (ext_mask).
// A transaction-level model checks the outputs on every negative edge, and
// the directed tests pin latencies and results with literal values.
// Build with ALU_DISPATCH_DIV0_CHECK_EN defined to cover the div-by-zero reject.
// -----------------------------------------------------------------------------
module tb_alu_op_dispatcher;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'd0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [W-1:0] unit_a, unit_b;
    logic [3:0]   unit_start;
    logic [3:0]   unit_working;
    logic [W-1:0] res_add, res_sub, res_mul, res_div;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [W-1:0] resp_data;
    logic         resp_err;
    logic         busy;

    logic [3:0]   ext_mask = 4'b0000;
    logic         auto_en  = 1'b1;
    logic         exp_abort = 1'b0;

    always #5 clk = ~clk;

    alu_op_dispatcher #(.WIDTH(W), .SETTLE_CYC(2), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .unit_a(unit_a), .unit_b(unit_b),
        .unit_start(unit_start), .unit_working(unit_working),
        .res_add(res_add), .res_sub(res_sub), .res_mul(res_mul), .res_div(res_div),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
    );

    // Unit emulation
    assign res_add = unit_a + unit_b;
    assign res_sub = unit_a - unit_b;
    assign res_mul = unit_a * unit_b;
    assign res_div = (unit_b == '0) ? '1 : unit_a / unit_b;
    assign unit_working = ext_mask | (auto_en ? unit_start : 4'b0000);

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] data;
        logic        err;
    } resp_t;

    resp_t       sb[$];
    logic        outstanding = 1'b0;
    logic        resp_shown  = 1'b0;
    logic        cur_rej     = 1'b0;
    logic [1:0]  cur_op      = 2'd0;
    logic [63:0] cur_a = '0, cur_b = '0;
    logic [3:0]  exp_st;
    logic        hs, acc;
    resp_t       nr;

    function automatic logic [63:0] arith(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return (b == 64'd0) ? '1 : a / b;
        endcase
    endfunction

    function automatic logic rejected(input logic [1:0] op, input logic [63:0] b);
`ifdef ALU_DISPATCH_DIV0_CHECK_EN
        return (op == 2'd3) && (b == 64'd0);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 1'b0;
            resp_shown  = 1'b0;
            sb.delete();
        end else begin
            chk("req_ready", 64'(req_ready), 64'(!outstanding));
            chk("busy", 64'(busy), 64'(outstanding));
            chk("ready_and_valid", 64'(req_ready & resp_valid), 64'd0);
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    chk("resp_data", resp_data, sb[0].data);
                    chk("resp_err", 64'(resp_err), 64'(sb[0].err));
                end
            end
            if (resp_shown) chk("resp_hold", 64'(resp_valid), 64'd1);
            if (outstanding) begin
                chk("unit_a", unit_a, cur_a);
                chk("unit_b", unit_b, cur_b);
            end
            exp_st = (outstanding && !resp_valid && !cur_rej) ? (4'b0001 << cur_op) : 4'b0000;
            if (unit_start != 4'b0000) chk("unit_start", 64'(unit_start), 64'(exp_st));

            // advance the model to the next cycle
            hs  = resp_valid && resp_ready && outstanding;
            acc = req_valid && !outstanding;
            if (hs) begin
                void'(sb.pop_front());
                outstanding = 1'b0;
                resp_shown  = 1'b0;
            end else if (resp_valid) begin
                resp_shown = 1'b1;
            end
            if (acc) begin
                outstanding = 1'b1;
                cur_op  = req_op;
                cur_a   = req_a;
                cur_b   = req_b;
                cur_rej = rejected(req_op, req_b);
                nr.err  = exp_abort || cur_rej;
                nr.data = nr.err ? 64'd0 : arith(req_op, req_a, req_b);
                sb.push_back(nr);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] st_log [0:255];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Cycles until resp_valid is seen, counted from the current post-edge point.
    task automatic wait_resp(output int lat, output logic [3:0] seen);
        lat = -1;
        seen = 4'b0000;
        for (int n = 1; n <= 200; n++) begin
            tick();
            st_log[n] = unit_start;
            if (resp_valid) begin
                lat = n;
                break;
            end
            seen = seen | unit_start;
        end
        if (lat < 0) chk("resp_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic take_resp(input int hold);
        resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    int         lat;
    logic [3:0] seen;

    initial begin
        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_unit_start", 64'(unit_start), 64'd0);
        chk("rst_unit_a", unit_a, 64'd0);
        chk("rst_unit_b", unit_b, 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();

        // mul 3*7, units respond at once: resp at cycle 4
        send(2'd2, 64'd3, 64'd7);
        wait_resp(lat, seen);
        chk("mul_latency", 64'(lat), 64'd4);
        chk("mul_data", resp_data, 64'd21);
        chk("mul_err", 64'(resp_err), 64'd0);
        for (int n = 1; n <= 3; n++) chk("mul_start_held", 64'(st_log[n]), 64'h4);
        chk("mul_start_dropped", 64'(unit_start), 64'd0);
        take_resp(0);

        // add while the div unit is busy for 10 cycles
        ext_mask = 4'b1000;
        send(2'd0, 64'd100, 64'd23);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("add_start_blocked", 64'(unit_start), 64'd0);
        end
        ext_mask = 4'b0000;
        wait_resp(lat, seen);
        chk("add_latency_after_free", 64'(lat), 64'd4);
        chk("add_data", resp_data, 64'd123);
        chk("add_err", 64'(resp_err), 64'd0);
        take_resp(0);

        // sub with peers stuck working: timeout after 64 cycles
        ext_mask  = 4'b0011;
        exp_abort = 1'b1;
        send(2'd1, 64'd50, 64'd8);
        exp_abort = 1'b0;
        wait_resp(lat, seen);
        chk("tmo_latency", 64'(lat), 64'd64);
        chk("tmo_data", resp_data, 64'd0);
        chk("tmo_err", 64'(resp_err), 64'd1);
        chk("tmo_start_never", 64'(seen | unit_start), 64'd0);
        ext_mask = 4'b0000;
        take_resp(5);

        // response held 5 cycles, then a back-to-back request
        send(2'd0, 64'd5, 64'd6);
        wait_resp(lat, seen);
        chk("b2b_first_data", resp_data, 64'd11);
        take_resp(5);
        chk("b2b_ready_after_hs", 64'(req_ready), 64'd1);
        send(2'd2, 64'd1000, 64'd1000);
        wait_resp(lat, seen);
        chk("b2b_latency", 64'(lat), 64'd4);
        chk("b2b_second_data", resp_data, 64'd1000000);
        take_resp(0);

        // peer glitch during settle sends the grant back; settle restarts
        send(2'd3, 64'd100, 64'd7);
        tick();
        tick();
        ext_mask = 4'b0001;
        tick();
        chk("glitch_start_held", 64'(unit_start), 64'h8);
        ext_mask = 4'b0000;
        wait_resp(lat, seen);
        chk("glitch_latency", 64'(lat), 64'd3);
        chk("glitch_data", resp_data, 64'd14);
        take_resp(0);

        // div by zero
        send(2'd3, 64'd9, 64'd0);
        wait_resp(lat, seen);
`ifdef ALU_DISPATCH_DIV0_CHECK_EN
        chk("div0_latency", 64'(lat), 64'd1);
        chk("div0_err", 64'(resp_err), 64'd1);
        chk("div0_data", resp_data, 64'd0);
        chk("div0_start_never", 64'(seen | unit_start), 64'd0);
`else
        chk("div0_latency", 64'(lat), 64'd4);
        chk("div0_err", 64'(resp_err), 64'd0);
        chk("div0_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("div0_started", 64'(seen), 64'h8);
`endif
        take_resp(0);

        // asynchronous reset while in GRANT
        auto_en = 1'b0;
        send(2'd2, 64'd3, 64'd7);
        tick();
        chk("grant_start", 64'(unit_start), 64'h4);
        #1 rst = 1'b1;
        #1;
        chk("async_start_drop", 64'(unit_start), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        auto_en = 1'b1;
        tick();
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);

        // resp_ready held high outside RESP is ignored
        resp_ready = 1'b1;
        send(2'd1, 64'd50, 64'd8);
        wait_resp(lat, seen);
        chk("rr_high_latency", 64'(lat), 64'd4);
        chk("rr_high_data", resp_data, 64'd42);
        tick();
        resp_ready = 1'b0;
        chk("rr_high_done", 64'(resp_valid), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
